// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and constants for the memory-stage request controller.
package mem_req_ctrl_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned TIMEOUT_DEF = 64;

  localparam logic [ADDR_W-1:0] WORD_ALIGN = 16'h0001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic is_unaligned(input logic [ADDR_W-1:0] addr);
    return |(addr & WORD_ALIGN);
  endfunction

endpackage

// File: rtl/mem_req_ctrl_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// Latency: count reflects an inc one cycle later.
// Backpressure: none; inc is sampled every cycle.
module mem_req_ctrl_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Pipeline front end for mem_system: one load/store per handshake, single-cycle strobe.
// Latency: hit 3 cycles accept->rsp_valid, miss = mem_system latency + 2, unaligned 1.
// Backpressure: req_ready only in IDLE/RESP; strobe withheld while mem_stall is high.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_done,
  input  logic              mem_stall,
  input  logic              mem_hit,
  input  logic              mem_err,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  acc_cnt
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  req_t              req_q;
  logic [DATA_W-1:0] rdata_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              accept, strobe, done_ok, tmo_hit;

  assign mem_addr = req_q.addr;
  assign mem_din  = req_q.wdata;
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    accept    = 1'b0;
    strobe    = 1'b0;
    done_ok   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = is_unaligned(req_addr) ? ST_ERR : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!mem_stall) begin
          strobe  = 1'b1;
          mem_rd  = ~req_q.wr;
          mem_wr  = req_q.wr;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // mem_err outranks a simultaneous Done; a real Done outranks the timeout.
        if (mem_err) begin
          state_d = ST_ERR;
        end else if (mem_done) begin
          done_ok = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = is_unaligned(req_addr) ? ST_ERR : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= '{wr: req_wr, addr: req_addr, wdata: req_wdata};
      end
      if (done_ok) begin
        rdata_q <= req_q.wr ? '0 : mem_dout;
      end
      if (strobe) begin
        tmo_q <= '0;
      end else if (state_q == ST_WAIT) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  mem_req_ctrl_sat_counter #(.WIDTH(CNT_W)) u_acc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (strobe),
    .count (acc_cnt)
  );

  mem_req_ctrl_sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (done_ok & mem_hit),
    .count (hit_cnt)
  );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural mem_system stub (hit/miss/hang/err).
module tb_mem_req_ctrl;
  import mem_req_ctrl_pkg::*;

  localparam int MISS_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_rd, mem_wr;
  logic [15:0] rsp_rdata, mem_addr, mem_din;
  logic [15:0] mem_dout = '0;
  logic        mem_done = 1'b0;
  logic        mem_stall = 1'b0;
  logic        mem_hit = 1'b0;
  logic        mem_err = 1'b0;
  logic [15:0] hit_cnt, acc_cnt;

  mem_req_ctrl #(.TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit),
    .mem_err(mem_err), .hit_cnt(hit_cnt), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- mem_system stub ----------------
  logic [15:0] backing [int];
  bit          cached  [int];
  bit          hang = 1'b0;
  bit          inj_err = 1'b0;
  int          extra = 0;
  int          busy = 0;
  int          hold = 0;
  logic        strobe_seen = 1'b0;
  logic        strobe_wr = 1'b0;
  logic [15:0] strobe_addr = '0;
  logic [15:0] strobe_din = '0;
  logic [15:0] p_addr = '0;
  logic        p_wr = 1'b0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  int          bad_strobes = 0;

  function automatic logic [15:0] rd_back(input logic [15:0] a);
    if (backing.exists(int'(a))) return backing[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  task automatic finish_access(input bit h);
    mem_done = 1'b1;
    mem_hit  = h;
    mem_err  = inj_err;
    mem_dout = p_wr ? 16'hDEAD : rd_back(p_addr);
    cached[int'(p_addr)] = 1'b1;
    mem_stall = (extra > 0);
    hold = extra;
  endtask

  always @(negedge clk) begin
    strobe_seen = (mem_rd | mem_wr) && !mem_stall;
    strobe_wr   = mem_wr;
    strobe_addr = mem_addr;
    strobe_din  = mem_din;
    if (mem_rd) rd_pulses++;
    if (mem_wr) wr_pulses++;
    if ((mem_rd | mem_wr) && mem_stall) bad_strobes++;
  end

  always @(posedge clk) begin
    #1;
    mem_done = 1'b0;
    mem_hit  = 1'b0;
    mem_err  = 1'b0;
    if (rst) begin
      busy = 0;
      hold = 0;
      mem_stall = 1'b0;
      mem_dout = '0;
      cached.delete();
    end else if (strobe_seen) begin
      p_addr = strobe_addr;
      p_wr   = strobe_wr;
      if (strobe_wr) backing[int'(strobe_addr)] = strobe_din;
      if (hang) mem_stall = 1'b1;
      else if (cached.exists(int'(strobe_addr))) finish_access(1'b1);
      else begin
        busy = MISS_LAT - 1;
        mem_stall = 1'b1;
      end
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) finish_access(1'b0);
    end else if (hold > 0) begin
      hold--;
      mem_stall = 1'b1;
    end else if (!hang) begin
      mem_stall = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic wr, input logic [15:0] a, input logic [15:0] d);
    chk("send_ready", req_ready, 1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_arrived", rsp_valid, 1);
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 1);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_err"},   rsp_err, 0);
    chk({pfx, "_rsp_rdata"}, rsp_rdata, 0);
    chk({pfx, "_mem_rd"},    mem_rd, 0);
    chk({pfx, "_mem_wr"},    mem_wr, 0);
    chk({pfx, "_mem_addr"},  mem_addr, 0);
    chk({pfx, "_mem_din"},   mem_din, 0);
    chk({pfx, "_hit_cnt"},   hit_cnt, 0);
    chk({pfx, "_acc_cnt"},   acc_cnt, 0);
  endtask

  logic [15:0] b2b_addr [4];
  logic [15:0] b2b_exp  [4];

  initial begin
    int lat, r0, bad0, idx, nrsp, in_resp_acc, spurious;
    logic acc_now;

    b2b_addr[0] = 16'h0010; b2b_exp[0] = 16'hA5B5;
    b2b_addr[1] = 16'h0124; b2b_exp[1] = 16'hBEEF;
    b2b_addr[2] = 16'h0180; b2b_exp[2] = 16'hA425;
    b2b_addr[3] = 16'h0010; b2b_exp[3] = 16'hA5B5;

    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: cold load misses, repeat hits
    send(1'b0, 16'h0010, 16'h0);
    wait_rsp(lat);
    chk("t1_miss_lat", lat, 6);
    chk("t1_miss_rdata", rsp_rdata, 16'hA5B5);
    chk("t1_miss_err", rsp_err, 0);
    chk("t1_miss_hit_cnt", hit_cnt, 0);
    chk("t1_miss_acc_cnt", acc_cnt, 1);
    chk("t1_rd_pulses", rd_pulses, 1);
    @(negedge clk);
    send(1'b0, 16'h0010, 16'h0);
    wait_rsp(lat);
    chk("t1_hit_lat", lat, 3);
    chk("t1_hit_rdata", rsp_rdata, 16'hA5B5);
    chk("t1_hit_cnt", hit_cnt, 1);
    chk("t1_acc_cnt", acc_cnt, 2);

    // 2: store then load back
    @(negedge clk);
    send(1'b1, 16'h0124, 16'hBEEF);
    wait_rsp(lat);
    chk("t2_st_lat", lat, 6);
    chk("t2_st_rdata", rsp_rdata, 0);
    chk("t2_st_err", rsp_err, 0);
    chk("t2_wr_pulses", wr_pulses, 1);
    @(negedge clk);
    send(1'b0, 16'h0124, 16'h0);
    wait_rsp(lat);
    chk("t2_ld_lat", lat, 3);
    chk("t2_ld_rdata", rsp_rdata, 16'hBEEF);
    chk("t2_ld_err", rsp_err, 0);
    chk("t2_hit_cnt", hit_cnt, 2);
    chk("t2_acc_cnt", acc_cnt, 4);

    // 3: unaligned load never reaches mem_system
    @(negedge clk);
    r0 = rd_pulses;
    send(1'b0, 16'h0013, 16'h0);
    wait_rsp(lat);
    chk("t3_lat", lat, 1);
    chk("t3_err", rsp_err, 1);
    chk("t3_rdata", rsp_rdata, 0);
    @(negedge clk);
    chk("t3_idle_ready", req_ready, 1);
    chk("t3_idle_valid", rsp_valid, 0);
    chk("t3_no_rd", rd_pulses - r0, 0);
    chk("t3_acc_cnt", acc_cnt, 4);

    // mem_err coincident with Done on a hit: error wins, no hit counted
    inj_err = 1'b1;
    send(1'b0, 16'h0010, 16'h0);
    wait_rsp(lat);
    inj_err = 1'b0;
    chk("terr_lat", lat, 3);
    chk("terr_err", rsp_err, 1);
    chk("terr_rdata", rsp_rdata, 0);
    chk("terr_hit_cnt", hit_cnt, 2);
    chk("terr_acc_cnt", acc_cnt, 5);

    // 4: hung mem_system -> timeout after 64 WAIT cycles
    @(negedge clk);
    hang = 1'b1;
    send(1'b0, 16'h0040, 16'h0);
    wait_rsp(lat);
    chk("t4_lat", lat, 66);
    chk("t4_err", rsp_err, 1);
    chk("t4_rdata", rsp_rdata, 0);
    @(negedge clk);
    chk("t4_idle_ready", req_ready, 1);
    chk("t4_idle_valid", rsp_valid, 0);
    chk("t4_acc_cnt", acc_cnt, 6);
    hang = 1'b0;
    repeat (2) @(negedge clk);

    // 5: back-to-back loads with req_valid held, stall lingering after each Done
    extra = 2;
    r0 = rd_pulses;
    bad0 = bad_strobes;
    idx = 0;
    nrsp = 0;
    in_resp_acc = 0;
    req_valid = 1'b1;
    req_wr = 1'b0;
    req_addr = b2b_addr[0];
    for (int cyc = 0; cyc < 300 && nrsp < 4; cyc++) begin
      acc_now = req_valid && req_ready;
      if (rsp_valid) begin
        chk("t5_rdata", rsp_rdata, b2b_exp[nrsp]);
        chk("t5_err", rsp_err, 0);
        nrsp++;
      end
      if (acc_now && idx > 0 && rsp_valid) in_resp_acc++;
      @(negedge clk);
      if (acc_now) begin
        idx++;
        if (idx < 4) req_addr = b2b_addr[idx];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("t5_nrsp", nrsp, 4);
    chk("t5_acc_in_resp", in_resp_acc, 3);
    chk("t5_rd_pulses", rd_pulses - r0, 4);
    chk("t5_strobe_in_stall", bad_strobes - bad0, 0);
    chk("t5_acc_cnt", acc_cnt, 10);
    chk("t5_hit_cnt", hit_cnt, 5);
    extra = 0;
    repeat (5) @(negedge clk);

    // 6: reset during WAIT of a miss drops the request
    send(1'b0, 16'h0300, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t6");
    rst = 1'b0;
    spurious = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) spurious++;
    end
    chk("t6_no_rsp", spurious, 0);
    send(1'b0, 16'h0010, 16'h0);
    wait_rsp(lat);
    chk("t6_after_lat", lat, 6);
    chk("t6_after_rdata", rsp_rdata, 16'hA5B5);
    chk("t6_after_acc_cnt", acc_cnt, 1);
    chk("t6_after_hit_cnt", hit_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
